// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//
// Definitions shared by the pipeline stages:
//   - funct3 encodings for loads (LB, LH, LW, LBU, LHU) and stores (SB, SH, SW)
//   - the writeback memory-access FSM state type
// ----------------------------------------------------------------------------
package riscv_pkg;

    // Load funct3 encodings
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    // Store funct3 encodings
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    // Writeback memory-access FSM.
    //   IDLE      : no access outstanding; a new request is issued from here
    //   WAIT_ACK  : request presented but not yet accepted by memory
    //   WAIT_DATA : load accepted, waiting for the read data
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } wb_state_t;

endpackage

// File: rtl/regfile.sv
// ----------------------------------------------------------------------------
// regfile
//
// 32 x 32 integer register file. x0 is hard-wired to zero and has no storage,
// so only x1..x31 are flops. All flops clear on the asynchronous active-low
// reset.
//
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   we, waddr, wdata single write port, committed at the rising edge
//   raddr1, rdata1   combinational read port 1
//   raddr2, rdata2   combinational read port 2
//
// Both read ports bypass the write port: a read of the register being written
// in the same cycle returns the new value, so execute never sees a stale
// operand for an instruction that is retiring right now.
// ----------------------------------------------------------------------------
module regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] regs [1:31];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Shared read logic for both ports: zero for x0, bypass on a matching
    // write, otherwise the stored value.
    function automatic logic [31:0] read_port(input logic [4:0] raddr);
        logic [31:0] value;
        value = 32'd0;
        if (raddr != 5'd0) begin
            if (we && (raddr == waddr)) begin
                value = wdata;
            end else begin
                value = regs[raddr];
            end
        end
        return value;
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

endmodule

// File: rtl/writeback.sv
// ----------------------------------------------------------------------------
// writeback
//
// Final stage of the three-stage RV32I pipeline. Consumes execute's registered
// wb_* outputs, runs the data-memory request/response handshake, aligns and
// extends load data, and commits results to the register file. Also supplies
// the bypassed register read ports used by execute, and stalls execute/fetch
// while a memory access is outstanding.
//
// Ports:
//   clk, reset                clock, asynchronous active-low reset
//   wb_valid                  writeback slot holds a live instruction
//   wb_alu_to_reg             instruction writes rd
//   wb_mem_to_reg             instruction is a load
//   wb_mem_write              instruction is a store
//   wb_dest_reg_sel           rd
//   wb_result                 ALU / link / LUI result
//   wb_alu_operation          funct3 (load width and signedness)
//   wb_mem_address            byte address of the load/store
//   wb_write_byte             store byte strobes
//   wb_write_data             store data, already lane-replicated
//   dmem_req/we/addr/wstrb/wdata  data-memory request
//   dmem_ready                memory accepts the request this cycle
//   dmem_rvalid, dmem_rdata   load response
//   rs1_sel, rs2_sel          execute read addresses
//   reg_rdata1, reg_rdata2    bypassed read data
//   wb_stall                  hold execute and fetch
//   rf_we, rf_waddr, rf_wdata register-file write this cycle
//   fsm_state                 current access FSM state (observability only)
//
// Handshake: a request transfers in a cycle where dmem_req and dmem_ready are
// both high; dmem_ready is meaningless while dmem_req is low. Once raised,
// dmem_req and its fields stay stable until that transfer. A load response
// transfers in the cycle dmem_rvalid is high while the FSM is in WAIT_DATA;
// dmem_rvalid in any other state is ignored.
// ----------------------------------------------------------------------------
module writeback
    import riscv_pkg::*;
#(
    parameter logic [1:0] RESET_STATE = 2'd0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        wb_valid,
    input  logic        wb_alu_to_reg,
    input  logic        wb_mem_to_reg,
    input  logic        wb_mem_write,
    input  logic [4:0]  wb_dest_reg_sel,
    input  logic [31:0] wb_result,
    input  logic [2:0]  wb_alu_operation,
    input  logic [31:0] wb_mem_address,
    input  logic [3:0]  wb_write_byte,
    input  logic [31:0] wb_write_data,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,

    input  logic [4:0]  rs1_sel,
    input  logic [4:0]  rs2_sel,
    output logic [31:0] reg_rdata1,
    output logic [31:0] reg_rdata2,

    output logic        wb_stall,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,

    output logic [1:0]  fsm_state
);

    wb_state_t   state;
    wb_state_t   state_next;

    logic        mem_op;
    logic        is_store;
    logic        load_done;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;

    // A store takes priority if execute ever flags both; a well-formed
    // instruction never does.
    assign is_store = wb_mem_write;
    assign mem_op   = wb_valid && (wb_mem_write || wb_mem_to_reg);

    // ------------------------------------------------------------------
    // Request fields. Execute holds wb_* stable while stalled, so driving
    // these straight from the inputs keeps them stable in WAIT_ACK too.
    // ------------------------------------------------------------------
    assign dmem_we    = is_store;
    assign dmem_addr  = {wb_mem_address[31:2], 2'b00};
    assign dmem_wstrb = is_store ? wb_write_byte : 4'b0000;
    assign dmem_wdata = wb_write_data;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= wb_state_t'(RESET_STATE);
        end else begin
            state <= state_next;
        end
    end

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // FSM next-state, request and stall
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        dmem_req   = 1'b0;
        wb_stall   = 1'b0;
        load_done  = 1'b0;

        case (state)
            IDLE: begin
                if (mem_op) begin
                    dmem_req = 1'b1;
                    if (is_store) begin
                        // An accepted store completes in its own cycle.
                        if (!dmem_ready) begin
                            wb_stall   = 1'b1;
                            state_next = WAIT_ACK;
                        end
                    end else begin
                        // A load always needs at least the data cycle.
                        wb_stall   = 1'b1;
                        state_next = dmem_ready ? WAIT_DATA : WAIT_ACK;
                    end
                end
            end

            WAIT_ACK: begin
                dmem_req = 1'b1;
                if (is_store) begin
                    wb_stall = !dmem_ready;
                    if (dmem_ready) begin
                        state_next = IDLE;
                    end
                end else begin
                    wb_stall = 1'b1;
                    if (dmem_ready) begin
                        state_next = WAIT_DATA;
                    end
                end
            end

            WAIT_DATA: begin
                if (dmem_rvalid) begin
                    load_done  = 1'b1;
                    state_next = IDLE;
                end else begin
                    wb_stall = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load alignment and extension
    // ------------------------------------------------------------------
    always_comb begin
        case (wb_mem_address[1:0])
            2'd0:    byte_lane = dmem_rdata[7:0];
            2'd1:    byte_lane = dmem_rdata[15:8];
            2'd2:    byte_lane = dmem_rdata[23:16];
            default: byte_lane = dmem_rdata[31:24];
        endcase

        // Halfword lane is chosen by bit 1 only; bit 0 is ignored.
        half_lane = wb_mem_address[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        case (wb_alu_operation)
            LB:      load_data = {{24{byte_lane[7]}}, byte_lane};
            LH:      load_data = {{16{half_lane[15]}}, half_lane};
            LW:      load_data = dmem_rdata;
            LBU:     load_data = {24'd0, byte_lane};
            LHU:     load_data = {16'd0, half_lane};
            default: load_data = dmem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Register-file write port. A load writes only in its data cycle; any
    // other instruction that targets rd writes in the cycle it is presented.
    // ------------------------------------------------------------------
    always_comb begin
        rf_waddr = wb_dest_reg_sel;
        if (load_done) begin
            rf_we    = (wb_dest_reg_sel != 5'd0);
            rf_wdata = load_data;
        end else begin
            rf_we    = wb_valid && wb_alu_to_reg && !wb_mem_to_reg
                       && (wb_dest_reg_sel != 5'd0);
            rf_wdata = wb_result;
        end
    end

    regfile u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr1 (rs1_sel),
        .raddr2 (rs2_sel),
        .rdata1 (reg_rdata1),
        .rdata2 (reg_rdata2)
    );

endmodule

// File: tb/tb_writeback.sv
// ----------------------------------------------------------------------------
// tb_writeback
//
// The bench plays both the execute stage (driving wb_*) and the data memory
// (driving dmem_ready/rvalid/rdata). Each instruction is driven as a
// transaction whose cycle-by-cycle expectations (request, stall, register
// write) follow from the chosen memory latencies. A register-array model
// tracks architectural state, and one compare process checks every cycle.
// ----------------------------------------------------------------------------
module tb_writeback;
    import riscv_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        wb_valid, wb_alu_to_reg, wb_mem_to_reg, wb_mem_write;
    logic [4:0]  wb_dest_reg_sel;
    logic [31:0] wb_result;
    logic [2:0]  wb_alu_operation;
    logic [31:0] wb_mem_address;
    logic [3:0]  wb_write_byte;
    logic [31:0] wb_write_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  rs1_sel, rs2_sel;
    logic [31:0] reg_rdata1, reg_rdata2;
    logic        wb_stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  fsm_state;

    writeback #(.RESET_STATE(2'd0)) dut (
        .clk              (clk),
        .reset            (reset),
        .wb_valid         (wb_valid),
        .wb_alu_to_reg    (wb_alu_to_reg),
        .wb_mem_to_reg    (wb_mem_to_reg),
        .wb_mem_write     (wb_mem_write),
        .wb_dest_reg_sel  (wb_dest_reg_sel),
        .wb_result        (wb_result),
        .wb_alu_operation (wb_alu_operation),
        .wb_mem_address   (wb_mem_address),
        .wb_write_byte    (wb_write_byte),
        .wb_write_data    (wb_write_data),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_wdata       (dmem_wdata),
        .dmem_ready       (dmem_ready),
        .dmem_rvalid      (dmem_rvalid),
        .dmem_rdata       (dmem_rdata),
        .rs1_sel          (rs1_sel),
        .rs2_sel          (rs2_sel),
        .reg_rdata1       (reg_rdata1),
        .reg_rdata2       (reg_rdata2),
        .wb_stall         (wb_stall),
        .rf_we            (rf_we),
        .rf_waddr         (rf_waddr),
        .rf_wdata         (rf_wdata),
        .fsm_state        (fsm_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic        run_checks = 1'b0;

    // Expectations for the current cycle, set by the driver tasks.
    logic        exp_req, exp_stall, exp_we, exp_mem_we;
    logic [4:0]  exp_waddr;
    logic [31:0] exp_wdata, exp_addr, exp_mem_wdata;
    logic [3:0]  exp_wstrb;

    logic [31:0] model_regs [32];
    logic [31:0] exp_q [$];   // expected load results, oldest first

    int          stall_count = 0;
    int          we_count = 0;
    logic [31:0] last_req_addr = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected load result computed from the architectural rules.
    function automatic logic [31:0] load_expect(input logic [2:0] f3, input logic [31:0] addr,
                                                input logic [31:0] word);
        logic [31:0] b, h;
        b = (word >> (8 * addr[1:0])) & 32'h0000_00FF;
        h = (word >> (16 * addr[1])) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] rs);
        if (rs == 5'd0) return 32'd0;
        if (exp_we && (rs == exp_waddr)) return exp_wdata;
        return model_regs[rs];
    endfunction

    // Architectural register model: commits the expected write at the edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) model_regs[i] <= 32'd0;
        end else if (exp_we && (exp_waddr != 5'd0)) begin
            model_regs[exp_waddr] <= exp_wdata;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (run_checks) begin
            check("dmem_req", {31'd0, dmem_req}, {31'd0, exp_req});
            check("wb_stall", {31'd0, wb_stall}, {31'd0, exp_stall});
            check("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
            if (exp_we) begin
                check("rf_waddr", {27'd0, rf_waddr}, {27'd0, exp_waddr});
                check("rf_wdata", rf_wdata, exp_wdata);
            end
            if (exp_req) begin
                check("dmem_we", {31'd0, dmem_we}, {31'd0, exp_mem_we});
                check("dmem_addr", dmem_addr, exp_addr);
                check("dmem_wstrb", {28'd0, dmem_wstrb}, {28'd0, exp_wstrb});
                if (exp_mem_we) check("dmem_wdata", dmem_wdata, exp_mem_wdata);
            end
            check("reg_rdata1", reg_rdata1, model_read(rs1_sel));
            check("reg_rdata2", reg_rdata2, model_read(rs2_sel));
        end
        if (wb_stall) stall_count++;
        if (rf_we) we_count++;
        if (dmem_req) last_req_addr = dmem_addr;
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        exp_req = 1'b0; exp_stall = 1'b0; exp_we = 1'b0; exp_mem_we = 1'b0;
        exp_waddr = 5'd0; exp_wdata = 32'd0; exp_addr = 32'd0;
        exp_mem_wdata = 32'd0; exp_wstrb = 4'd0;
    endtask

    task automatic zero_inputs();
        wb_valid = 1'b0; wb_alu_to_reg = 1'b0; wb_mem_to_reg = 1'b0; wb_mem_write = 1'b0;
        wb_dest_reg_sel = 5'd0; wb_result = 32'd0; wb_alu_operation = 3'd0;
        wb_mem_address = 32'd0; wb_write_byte = 4'd0; wb_write_data = 32'd0;
        dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        rs1_sel = 5'd0; rs2_sel = 5'd0;
    endtask

    task automatic random_reads();
        rs1_sel = ($urandom_range(0, 1) == 1) ? wb_dest_reg_sel : 5'($urandom_range(0, 31));
        rs2_sel = 5'($urandom_range(0, 31));
    endtask

    // Empty slot with garbage fields; nothing may happen.
    task automatic idle_cycle();
        next_cycle();
        wb_valid = 1'b0;
        wb_alu_to_reg = 1'($urandom_range(0, 1));
        wb_mem_to_reg = 1'($urandom_range(0, 1));
        wb_mem_write = 1'($urandom_range(0, 1));
        wb_dest_reg_sel = 5'($urandom_range(0, 31));
        wb_result = $urandom();
        wb_alu_operation = 3'($urandom_range(0, 7));
        wb_mem_address = $urandom();
        wb_write_byte = 4'($urandom_range(0, 15));
        wb_write_data = $urandom();
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rvalid = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom();
        random_reads();
        clear_exp();
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] result,
                          input logic to_reg, input logic stray_rvalid);
        next_cycle();
        wb_valid = 1'b1; wb_alu_to_reg = to_reg; wb_mem_to_reg = 1'b0; wb_mem_write = 1'b0;
        wb_dest_reg_sel = rd; wb_result = result;
        wb_alu_operation = 3'($urandom_range(0, 7));
        wb_mem_address = $urandom(); wb_write_byte = 4'($urandom_range(0, 15));
        wb_write_data = $urandom();
        dmem_ready = 1'($urandom_range(0, 1));
        dmem_rvalid = stray_rvalid; dmem_rdata = $urandom();
        random_reads();
        clear_exp();
        exp_we = to_reg && (rd != 5'd0);
        exp_waddr = rd;
        exp_wdata = result;
    endtask

    // Store accepted after ready_delay cycles of dmem_ready low.
    task automatic store(input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] data, input int ready_delay);
        for (int k = 0; k <= ready_delay; k++) begin
            next_cycle();
            if (k == 0) begin
                wb_valid = 1'b1; wb_alu_to_reg = 1'b0; wb_mem_to_reg = 1'b0; wb_mem_write = 1'b1;
                wb_dest_reg_sel = 5'($urandom_range(0, 31)); wb_result = $urandom();
                wb_alu_operation = 3'($urandom_range(0, 2));
                wb_mem_address = addr; wb_write_byte = strb; wb_write_data = data;
            end
            dmem_ready = (k == ready_delay);
            dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom();
            random_reads();
            clear_exp();
            exp_req = 1'b1; exp_mem_we = 1'b1;
            exp_addr = {addr[31:2], 2'b00};
            exp_wstrb = strb; exp_mem_wdata = data;
            exp_stall = (k != ready_delay);
        end
    endtask

    // Load: accepted after ready_delay cycles, data data_delay cycles later.
    // With abort set, returns one cycle into the data wait.
    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                        input logic [31:0] word, input int ready_delay, input int data_delay,
                        input logic abort);
        exp_q.push_back(load_expect(f3, addr, word));
        for (int k = 0; k <= ready_delay; k++) begin
            next_cycle();
            if (k == 0) begin
                wb_valid = 1'b1; wb_alu_to_reg = 1'b1; wb_mem_to_reg = 1'b1; wb_mem_write = 1'b0;
                wb_dest_reg_sel = rd; wb_result = $urandom(); wb_alu_operation = f3;
                wb_mem_address = addr; wb_write_byte = 4'($urandom_range(0, 15));
                wb_write_data = $urandom();
            end
            dmem_ready = (k == ready_delay);
            dmem_rvalid = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom();
            random_reads();
            clear_exp();
            exp_req = 1'b1; exp_mem_we = 1'b0; exp_wstrb = 4'd0;
            exp_addr = {addr[31:2], 2'b00};
            exp_stall = 1'b1;
        end
        if (abort) begin
            next_cycle();
            dmem_ready = 1'($urandom_range(0, 1));
            dmem_rvalid = 1'b0;
            random_reads();
            clear_exp();
            exp_stall = 1'b1;
            void'(exp_q.pop_back());
            return;
        end
        for (int j = 1; j <= data_delay; j++) begin
            next_cycle();
            dmem_ready = 1'($urandom_range(0, 1));
            dmem_rvalid = (j == data_delay);
            dmem_rdata = (j == data_delay) ? word : $urandom();
            random_reads();
            clear_exp();
            exp_stall = (j != data_delay);
            if (j == data_delay) begin
                exp_wdata = exp_q.pop_front();
                exp_waddr = rd;
                exp_we = (rd != 5'd0);
            end
        end
    endtask

    // Read a register through port 1 in an idle cycle and pin the value.
    task automatic expect_reg(input logic [4:0] idx, input logic [31:0] val);
        idle_cycle();
        rs1_sel = idx;
        @(negedge clk);
        check("lit_model_reg", model_regs[idx], val);
        check("lit_reg_rdata1", reg_rdata1, val);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin
        zero_inputs();
        clear_exp();
        reset = 1'b0;
        repeat (2) next_cycle();
        run_checks = 1'b1;
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("reset_fsm_state", {30'd0, fsm_state}, 32'd0);
        check("reset_stall", {31'd0, wb_stall}, 32'd0);

        // ALU writeback with same-cycle bypass
        alu_op(5'd5, 32'h0000_1234, 1'b1, 1'b0);
        rs1_sel = 5'd5;
        @(negedge clk);
        check("lit_bypass_rd1", reg_rdata1, 32'h0000_1234);
        expect_reg(5'd5, 32'h0000_1234);

        // rd = 0 is never written
        alu_op(5'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        rs1_sel = 5'd0;
        @(negedge clk);
        check("lit_x0_rd1", reg_rdata1, 32'd0);
        check("lit_x0_we", {31'd0, rf_we}, 32'd0);

        // Byte and half loads, immediate ready, data next cycle
        stall_count = 0;
        load(LB, 32'h0000_0103, 5'd6, 32'h80FF_0000, 0, 1, 1'b0);
        @(negedge clk);
        check("lit_lb_stall_cycles", stall_count, 32'd1);
        expect_reg(5'd6, 32'hFFFF_FF80);
        load(LBU, 32'h0000_0103, 5'd7, 32'h80FF_0000, 0, 1, 1'b0);
        expect_reg(5'd7, 32'h0000_0080);
        load(LH, 32'h0000_0102, 5'd8, 32'h7FFF_8001, 0, 1, 1'b0);
        expect_reg(5'd8, 32'h0000_7FFF);
        load(LHU, 32'h0000_0100, 5'd9, 32'h7FFF_8001, 0, 1, 1'b0);
        expect_reg(5'd9, 32'h0000_8001);

        // Halfword store held off for three cycles
        stall_count = 0;
        we_count = 0;
        store(32'h0000_0206, 4'b1100, 32'hABCD_ABCD, 3);
        @(negedge clk);
        check("lit_sh_stall_cycles", stall_count, 32'd3);
        check("lit_sh_rf_writes", we_count, 32'd0);
        check("lit_sh_addr", last_req_addr, 32'h0000_0204);

        // Stray rvalid during an ALU op is ignored
        alu_op(5'd10, 32'h0000_55AA, 1'b1, 1'b1);
        expect_reg(5'd10, 32'h0000_55AA);

        // Reset while waiting for load data, then a late rvalid
        load(LW, 32'h0000_0300, 5'd11, 32'hCAFE_F00D, 0, 3, 1'b1);
        next_cycle();
        reset = 1'b0;
        zero_inputs();
        clear_exp();
        next_cycle();
        reset = 1'b1;
        next_cycle();
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("lit_abort_fsm_state", {30'd0, fsm_state}, 32'd0);
        check("lit_abort_we", {31'd0, rf_we}, 32'd0);
        check("lit_abort_stall", {31'd0, wb_stall}, 32'd0);
        expect_reg(5'd11, 32'd0);

        // Randomized mix
        for (int n = 0; n < 250; n++) begin
            case ($urandom_range(0, 3))
                0: idle_cycle();
                1: alu_op(5'($urandom_range(0, 31)), $urandom(), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
                2: store($urandom(), 4'($urandom_range(1, 15)), $urandom(), $urandom_range(0, 3));
                default: load(3'($urandom_range(0, 7)), $urandom(), 5'($urandom_range(0, 31)),
                              $urandom(), $urandom_range(0, 3), $urandom_range(1, 3), 1'b0);
            endcase
        end
        idle_cycle();
        @(negedge clk);
        check("end_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback.md
# writeback

Final stage of the three-stage RV32I pipeline. The block consumes the execute stage's registered `wb_*` outputs. It owns the data-memory request/response handshake, aligns and sign-extends load data, and commits results to the 32×32 integer register file. It also provides the bypassed register read ports that execute uses, and asserts a stall back to execute while a memory access is outstanding.

## Interface
Parameters:
- `RESET_STATE`, `2'd0`: FSM encoding of IDLE; other states follow.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-low.
- `wb_valid`, in, 1: writeback slot holds a live instruction.
- `wb_alu_to_reg`, in, 1: instruction writes rd (ALU/LUI/JAL/JALR/load).
- `wb_mem_to_reg`, in, 1: instruction is a load.
- `wb_mem_write`, in, 1: instruction is a store.
- `wb_dest_reg_sel`, in, 5: rd.
- `wb_result`, in, 32: ALU/link/LUI result.
- `wb_alu_operation`, in, 3: funct3 (load width/sign).
- `wb_mem_address`, in, 32: byte address of load/store.
- `wb_write_byte`, in, 4: store byte strobes.
- `wb_write_data`, in, 32: store data, already lane-replicated.
- `dmem_req`, out, 1: memory request valid.
- `dmem_we`, out, 1: 1 = store, 0 = load.
- `dmem_addr`, out, 32: `{wb_mem_address[31:2], 2'b00}`.
- `dmem_wstrb`, out, 4: byte strobes; 0 for loads.
- `dmem_wdata`, out, 32: store data.
- `dmem_ready`, in, 1: memory accepts request this cycle.
- `dmem_rvalid`, in, 1: load data valid.
- `dmem_rdata`, in, 32: load word.
- `rs1_sel`, `rs2_sel`, in, 5: execute read addresses.
- `reg_rdata1`, `reg_rdata2`, out, 32: bypassed read data.
- `wb_stall`, out, 1: hold execute and fetch.
- `rf_we`, out, 1: register-file write this cycle.
- `rf_waddr`, out, 5: write address.
- `rf_wdata`, out, 32: write data.

## Operation
- FSM states:
  - IDLE: in IDLE with `wb_valid && (wb_mem_write || wb_mem_to_reg)`, drive `dmem_req=1`. Request fields are combinational from the inputs, which execute holds stable under stall.
  - Store accepted (`dmem_ready`) → stay IDLE. Store not accepted → WAIT_ACK.
  - Load accepted → WAIT_DATA. Load not accepted → WAIT_ACK.
  - WAIT_ACK: `dmem_req` held with the same fields. On `dmem_ready`, a store → IDLE and a load → WAIT_DATA.
  - WAIT_DATA: `dmem_req=0`. On `dmem_rvalid`, write the extracted data to rd and return to IDLE.
- `dmem_rvalid` is ignored outside WAIT_DATA. `dmem_ready` is ignored when `dmem_req=0`.
- `wb_stall` = (IDLE & mem op & !(store & dmem_ready)) | WAIT_ACK&!(store&dmem_ready) | (WAIT_DATA & !dmem_rvalid).
- Load extraction uses `wb_mem_address[1:0]`:
  - LB (0): sign-extended byte lane.
  - LH (1): sign-extended half selected by bit 1; bit 0 is ignored.
  - LW (2): full word; `[1:0]` is ignored.
  - LBU (4), LHU (5): zero-extended byte or half.
  - Any other funct3: raw word.
- Register writes:
  - Non-load: `rf_we = wb_valid & wb_alu_to_reg & !wb_mem_to_reg & (rd≠0)`, with `rf_wdata = wb_result`.
  - Load: `rf_we` only in the `dmem_rvalid` cycle in WAIT_DATA, with rd≠0.
- Register file: x0 always reads 0. Reads are combinational. Bypass rule: if `rf_we && rs==rf_waddr && rs≠0`, the read returns `rf_wdata`.

## Timing
- Reset values:
  - FSM in IDLE.
  - All 31 registers are 0.
  - `rf_we=0`, `wb_stall=0`.
  - `dmem_req=0`, because execute resets `wb_*` to 0.
- Reset mid-operation aborts the pending access with no register write. A late `rvalid` after reset is ignored.
- ALU writeback: latency 0. The write commits at the posedge ending the cycle.
- Store with immediate ready: 1 cycle, no stall.
- Load: minimum 2 cycles (request plus data), i.e. the stall lasts exactly one cycle when `rvalid` arrives the cycle after acceptance.
- `wb_stall` deasserts in the cycle the access completes, so execute advances at that posedge.

## Structure
- Shared package `riscv_pkg` holds:
  - funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW.
  - The FSM state typedef (IDLE, WAIT_ACK, WAIT_DATA).
- Sub-module `regfile` contains 31 flops with async clear, 1 write port, 2 bypassed read ports.
- Load alignment and the FSM stay in `writeback`.

## Test plan
- ALU writeback, no memory access:
  - Stimulus: `wb_result=0x1234`, rd=5, `rs1_sel=5` in the same cycle.
  - Response: `reg_rdata1=0x1234` via bypass; after the posedge, reg 5 = 0x1234. rd=0 variant: reg 0 still reads 0.
- LB at addr `0x103`, `rdata=0x80FF_0000`, ready immediate, `rvalid` next cycle:
  - Response: `wb_stall` is 1 for the request cycle only.
  - rd receives `0xFFFF_FF80`. An LBU at the same address gives `0x0000_0080`.
- LH at addr `0x102`, `rdata=0x7FFF_8001` → rd=`0x0000_7FFF`. LHU at `0x100` → rd=`0x0000_8001`.
- SH at `0x206`, `wb_write_byte=1100`, `dmem_ready` low for 3 cycles:
  - Response: `dmem_req` and fields stay stable (`dmem_addr=0x204`) with `wb_stall=1` for 3 cycles.
  - Completion takes 4 cycles with no `rf_we`.
- Reset asserted in WAIT_DATA, then `dmem_rvalid` pulses after release:
  - Response: FSM in IDLE, no register write, `wb_stall=0`.
- Stray `dmem_rvalid` in IDLE during an ALU op:
  - Response: only the ALU result is written; load data is ignored.
